// File: rtl/wiener_block_to_raster_axis.sv
// wiener_block_to_raster_axis: reorders 8x8 block-order pixels into a raster AXI4-Stream through a ping-pong strip buffer.
// Defining RASTER_OUT_CHECKSUM_EN adds a per-frame checksum of the output pixels.
module wiener_block_to_raster_axis #(
    parameter int BYTE_DATA_WIDTH = 8,
    parameter int PIXEL_WIDTH = 3*BYTE_DATA_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int MAX_WIDTH = 1280
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic                  overflow_err,
    output logic                  sof_err
`ifdef RASTER_OUT_CHECKSUM_EN
    ,
    output logic [31:0]           checksum,
    output logic                  checksum_valid
`endif
);
    localparam int DEPTH = BLOCK_SIZE*MAX_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(2*DEPTH);
    localparam int CW = $clog2(BLOCK_SIZE);
    localparam int EW = PIXEL_WIDTH + 3;
    typedef enum logic [1:0] {IDLE, STREAM, DONE_STRIP} state_t;
    state_t state, state_nx;
    logic [PIXEL_WIDTH-1:0] mem [2*DEPTH];
    logic [15:0] width_r, height_r, blk_col, blk_row, drain_col;
    logic [CW-1:0] col_in_blk, row_in_blk;
    logic fill_bank, drain_bank;
    logic [1:0] full, bank_first, bank_last;
    logic [AW-1:0] wr_addr, rd_addr, strip_last;
    logic [IW-1:0] wr_idx, rd_idx;
    // Buffer entries carry {frame_last, user, last, pixel}.
    logic [EW-1:0] out_q, skid_q, rd_entry;
    logic out_v, skid_v, hs, issue, fill_full, wr_en, pos_zero, strip_end, last_row, col_last, row_last;
    logic unused_bits;
    assign unused_bits = ^in_data[DATA_WIDTH-1:PIXEL_WIDTH];
    assign hs = out_v && m_axis_tready;
    // The skid only stays occupied while the consumer stalls, so that is the sole reason to hold off a read.
    assign issue = state == STREAM && !(skid_v && !m_axis_tready);
    assign strip_last = AW'(width_r * BLOCK_SIZE - 1);
    // A bank being released this cycle counts as empty for the incoming pixel.
    assign fill_full = full[fill_bank] && !(state == DONE_STRIP && drain_bank == fill_bank);
    assign wr_en = in_valid && !fill_full;
    assign col_last = col_in_blk == CW'(BLOCK_SIZE-1);
    assign row_last = row_in_blk == CW'(BLOCK_SIZE-1);
    assign pos_zero = col_in_blk == '0 && row_in_blk == '0 && blk_col == '0;
    assign strip_end = col_last && row_last && blk_col == 16'(width_r / BLOCK_SIZE) - 16'd1;
    assign last_row = blk_row == 16'(height_r / BLOCK_SIZE) - 16'd1;
    assign wr_addr = in_sof ? '0 : AW'(row_in_blk * width_r + blk_col * BLOCK_SIZE + col_in_blk);
    assign wr_idx = IW'(fill_bank ? DEPTH : 0) + IW'(wr_addr);
    assign rd_idx = IW'(drain_bank ? DEPTH : 0) + IW'(rd_addr);
    assign rd_entry = {bank_last[drain_bank] && rd_addr == strip_last, bank_first[drain_bank] && rd_addr == '0,
                       drain_col == width_r - 16'd1, mem[rd_idx]};
    assign m_axis_tdata = {{(DATA_WIDTH-PIXEL_WIDTH){1'b0}}, out_q[PIXEL_WIDTH-1:0]};
    assign m_axis_tvalid = out_v;
    assign m_axis_tlast = out_v && out_q[PIXEL_WIDTH];
    assign m_axis_tuser = out_v && out_q[PIXEL_WIDTH+1];
    always_ff @(posedge clk) if (wr_en) mem[wr_idx] <= in_data[PIXEL_WIDTH-1:0];
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = full[drain_bank] ? STREAM : IDLE;
        else if (state == STREAM) state_nx = (issue && rd_addr == strip_last) ? DONE_STRIP : STREAM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            width_r <= '0; height_r <= '0; blk_col <= '0; blk_row <= '0; drain_col <= '0;
            col_in_blk <= '0; row_in_blk <= '0; fill_bank <= 1'b0; drain_bank <= 1'b0;
            full <= '0; bank_first <= '0; bank_last <= '0; rd_addr <= '0;
            out_q <= '0; skid_q <= '0; out_v <= 1'b0; skid_v <= 1'b0;
            frame_done <= 1'b0; overflow_err <= 1'b0; sof_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                rd_addr <= '0;
                drain_col <= '0;
            end
            if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                drain_col <= rd_entry[PIXEL_WIDTH] ? '0 : drain_col + 16'd1;
            end
            if (state == DONE_STRIP) begin
                full[drain_bank] <= 1'b0;
                drain_bank <= ~drain_bank;
            end
            if (in_valid && fill_full) overflow_err <= 1'b1;
            if (wr_en && in_sof) begin
                width_r <= frame_width;
                height_r <= frame_height;
                sof_err <= sof_err || !pos_zero;
                col_in_blk <= CW'(1);
                row_in_blk <= '0;
                blk_col <= '0;
                blk_row <= '0;
            end else if (wr_en) begin
                col_in_blk <= col_last ? '0 : col_in_blk + 1'b1;
                if (col_last) row_in_blk <= row_last ? '0 : row_in_blk + 1'b1;
                if (col_last && row_last) blk_col <= strip_end ? '0 : blk_col + 16'd1;
                if (strip_end) begin
                    full[fill_bank] <= 1'b1;
                    bank_first[fill_bank] <= blk_row == '0;
                    bank_last[fill_bank] <= last_row;
                    fill_bank <= ~fill_bank;
                    blk_row <= last_row ? '0 : blk_row + 16'd1;
                end
            end
            if (!out_v || hs) begin
                out_v <= skid_v || issue;
                out_q <= skid_v ? skid_q : rd_entry;
                skid_v <= skid_v && issue;
                skid_q <= rd_entry;
            end else if (issue) begin
                skid_v <= 1'b1;
                skid_q <= rd_entry;
            end
            frame_done <= hs && out_q[EW-1];
        end
    end
`ifdef RASTER_OUT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
            checksum_valid <= 1'b0;
        end else begin
            if (hs) checksum <= (out_q[PIXEL_WIDTH+1] ? 32'd0 : checksum) + 32'(out_q[PIXEL_WIDTH-1:0]);
            checksum_valid <= hs && out_q[EW-1];
        end
    end
`endif
endmodule

// File: doc/wiener_block_to_raster_axis.md
Name: wiener_block_to_raster_axis

Overview:
- Downstream stage of the Wiener filter path. Consumes filtered pixels, which arrive in block order: 8x8 blocks, row-major inside each block, blocks left-to-right then top-to-bottom.
- Re-orders them into raster order through a ping-pong strip buffer, where each bank holds BLOCK_SIZE full-width lines.
- Emits an AXI4-Stream video output: tuser marks the first pixel of the frame, tlast marks the last pixel of each line.
- Frees the top level from writing filtered blocks back to memory before display or capture.

Parameters:
- BYTE_DATA_WIDTH, 8, bits per colour channel.
- PIXEL_WIDTH, 3*BYTE_DATA_WIDTH (24), RGB pixel width.
- DATA_WIDTH, 32, AXI-stream tdata width; the pixel is placed in [23:0] and [31:24] is zero.
- BLOCK_SIZE, 8, block edge length in pixels.
- MAX_WIDTH, 1280, maximum supported frame_width; sets bank depth to BLOCK_SIZE*MAX_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- frame_width  in  16  pixels per line; a multiple of BLOCK_SIZE, <= MAX_WIDTH; sampled at in_sof.
- frame_height  in  16  lines per frame; a multiple of BLOCK_SIZE; sampled at in_sof.
- in_valid  in  1  one filtered pixel present this cycle. There is no backpressure.
- in_data  in  DATA_WIDTH  filtered pixel; only [23:0] is used.
- in_sof  in  1  qualifies in_valid: this pixel is the first pixel of the frame.
- m_axis_tdata  out  DATA_WIDTH  raster pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- frame_done  out  1  one-cycle pulse after the final pixel of the frame is accepted.
- overflow_err  out  1  sticky: a pixel arrived while both banks were full.
- sof_err  out  1  sticky: in_sof arrived with the fill position not at 0.

Behaviour:
- Reset (rst=1 on a clk edge) clears everything:
  - all outputs 0;
  - both banks marked empty;
  - fill and drain counters 0;
  - fill bank = 0, drain bank = 0;
  - sticky errors cleared.
- Fill side, per accepted in_valid pixel:
  - write address = row_in_blk*frame_width + blk_col*BLOCK_SIZE + col_in_blk.
  - Counter order: col_in_blk, then row_in_blk, then blk_col.
  - After pixel (BLOCK_SIZE-1, BLOCK_SIZE-1) of the last blk_col (frame_width/BLOCK_SIZE - 1):
    - mark the bank full;
    - toggle the fill bank;
    - clear blk_col;
    - increment blk_row.
  - After the last blk_row (frame_height/BLOCK_SIZE - 1), blk_row wraps to 0.
- in_sof (with in_valid):
  - latches frame_width and frame_height;
  - forces the pixel to position 0 of the current fill bank.
  - If the fill position was not 0, set sof_err and discard the partial strip. Drain is unaffected.
- Overflow: in_valid while the fill bank is still full drops the pixel, sets overflow_err, and does not advance the counters.
- Drain side states:
  - IDLE: on drain bank full, go to STREAM.
  - STREAM: read the bank linearly, address 0 .. BLOCK_SIZE*frame_width-1.
  - DONE_STRIP: mark the bank empty, toggle the drain bank, return to IDLE.
- Output register, read pipeline and handshake:
  - Memory read latency is 1 cycle; a 1-entry output register plus a 1-entry skid give full throughput (one pixel per cycle when tready=1).
  - tdata, tlast and tuser are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Output markers:
  - tlast = 1 when drain column == frame_width-1.
  - tuser = 1 on address 0 of strip 0 of the frame only.
  - frame_done pulses the cycle after the handshake of the last pixel of the last strip.
- Latency: the first output pixel is valid 2 cycles after the bank becomes full (bank full → IDLE→STREAM → first read → output register).
- Fill and drain may run in the same cycle on different banks. If a bank is drained and refilled at the same edge, empty takes effect before the full check, so no false overflow occurs.
- Reset mid-operation discards all buffered data. No partial frame is emitted.

Optional Feature:
- Macro RASTER_OUT_CHECKSUM_EN.
- When defined:
  - adds output checksum (32) and checksum_valid (1);
  - checksum = wrapping sum of the 24-bit pixels of all output beats of the frame;
  - checksum_valid pulses together with frame_done;
  - the checksum is cleared at the tuser beat.
- When undefined, these ports and the logic are absent. All other behaviour is identical.

Test Plan:
- Width=16, height=16, pixel value = raster index (0..255), fed in block order at 1 pixel/cycle, tready=1 → output is 0..255 in raster order; tuser on beat 0 only; tlast on beats 15, 31, ..., 255; frame_done 1 cycle after beat 255.
- Same frame, tready toggled 1/0 every cycle → identical data sequence, no duplicated or dropped beats, tdata stable while stalled, overflow_err=0.
- tready=0 held while 3 strips (width=16) are fed → strips 0 and 1 buffered; all 128 pixels of strip 2 dropped; overflow_err=1; after tready=1, exactly 256 beats emerge with values 0..255.
- in_sof asserted at fill position 37 → sof_err=1; the new frame starts at position 0; the next output strip contains only new-frame pixels, with tuser on its first beat.
- rst asserted mid-drain (beat 50) → next cycle tvalid=0 and all flags 0; a full new 16x16 frame streams correctly afterwards.
- RASTER_OUT_CHECKSUM_EN defined, 16x16 frame with all pixels 0x010203 → checksum = 256*0x010203 = 0x01020300, checksum_valid coincides with frame_done.
